// File: rtl/tlb.sv
`default_nettype none
// ============================================================================
// Module  : tlb
// Brief   : Unified LoongArch-style TLB with two combinational search ports,
//           a tlbrd read port, a tlbwr/tlbfill write port and invtlb.
// Revision: 1.0 - initial release
// ============================================================================

package tlb_pkg;
    typedef struct packed {
        logic        found;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_result_t;
endpackage

module tlb
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [18:0]       s0_vppn,
    input  logic              s0_va_bit12,
    input  logic [9:0]        s0_asid,
    output tlb_result_t       s0_result,
    output logic [IDXW-1:0]   s0_index,
    input  logic [18:0]       s1_vppn,
    input  logic              s1_va_bit12,
    input  logic [9:0]        s1_asid,
    output tlb_result_t       s1_result,
    output logic [IDXW-1:0]   s1_index,
    input  logic              we,
    input  logic [IDXW-1:0]   w_index,
    input  logic              w_e,
    input  logic [18:0]       w_vppn,
    input  logic [5:0]        w_ps,
    input  logic              w_g,
    input  logic [9:0]        w_asid,
    input  logic [19:0]       w_ppn0,
    input  logic [1:0]        w_plv0,
    input  logic [1:0]        w_mat0,
    input  logic              w_d0,
    input  logic              w_v0,
    input  logic [19:0]       w_ppn1,
    input  logic [1:0]        w_plv1,
    input  logic [1:0]        w_mat1,
    input  logic              w_d1,
    input  logic              w_v1,
    input  logic [IDXW-1:0]   r_index,
    output logic              r_e,
    output logic [18:0]       r_vppn,
    output logic [5:0]        r_ps,
    output logic              r_g,
    output logic [9:0]        r_asid,
    output logic [19:0]       r_ppn0,
    output logic [1:0]        r_plv0,
    output logic [1:0]        r_mat0,
    output logic              r_d0,
    output logic              r_v0,
    output logic [19:0]       r_ppn1,
    output logic [1:0]        r_plv1,
    output logic [1:0]        r_mat1,
    output logic              r_d1,
    output logic              r_v1,
    input  logic              inv_en,
    input  logic [4:0]        inv_op,
    input  logic [9:0]        inv_asid,
    input  logic [18:0]       inv_vppn
);

    localparam logic [5:0] c_ps_4k = 6'd12;

    logic              r_tlb_e    [TLBNUM];
    logic [18:0]       r_tlb_vppn [TLBNUM];
    logic [5:0]        r_tlb_ps   [TLBNUM];
    logic              r_tlb_g    [TLBNUM];
    logic [9:0]        r_tlb_asid [TLBNUM];
    logic [19:0]       r_tlb_ppn0 [TLBNUM];
    logic [1:0]        r_tlb_plv0 [TLBNUM];
    logic [1:0]        r_tlb_mat0 [TLBNUM];
    logic              r_tlb_d0   [TLBNUM];
    logic              r_tlb_v0   [TLBNUM];
    logic [19:0]       r_tlb_ppn1 [TLBNUM];
    logic [1:0]        r_tlb_plv1 [TLBNUM];
    logic [1:0]        r_tlb_mat1 [TLBNUM];
    logic              r_tlb_d1   [TLBNUM];
    logic              r_tlb_v1   [TLBNUM];

    logic [TLBNUM-1:0] w_inv_hit;

    // Any ps other than 12 behaves as a 2 MiB page (compare VA[31:22] only).
    function automatic logic va_match(input logic [5:0] ps, input logic [18:0] a,
                                      input logic [18:0] b);
        return (ps == c_ps_4k) ? (a == b) : (a[18:9] == b[18:9]);
    endfunction

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [18:0]     w_vppn_q;
            logic            w_bit12_q;
            logic [9:0]      w_asid_q;
            tlb_result_t     w_res;
            logic [IDXW-1:0] w_idx;
            logic            w_odd;

            assign w_vppn_q  = (p == 0) ? s0_vppn     : s1_vppn;
            assign w_bit12_q = (p == 0) ? s0_va_bit12 : s1_va_bit12;
            assign w_asid_q  = (p == 0) ? s0_asid     : s1_asid;

            // Scan from the top so the lowest matching index is the last writer.
            always_comb begin
                w_res = '0;
                w_idx = '0;
                w_odd = 1'b0;
                for (int i = TLBNUM - 1; i >= 0; i--) begin
                    if (r_tlb_e[i] && (r_tlb_g[i] || r_tlb_asid[i] == w_asid_q) &&
                        va_match(r_tlb_ps[i], r_tlb_vppn[i], w_vppn_q)) begin
                        w_idx     = IDXW'(i);
                        w_odd     = (r_tlb_ps[i] == c_ps_4k) ? w_bit12_q : w_vppn_q[8];
                        w_res.found = 1'b1;
                        w_res.ps  = r_tlb_ps[i];
                        w_res.ppn = w_odd ? r_tlb_ppn1[i] : r_tlb_ppn0[i];
                        w_res.plv = w_odd ? r_tlb_plv1[i] : r_tlb_plv0[i];
                        w_res.mat = w_odd ? r_tlb_mat1[i] : r_tlb_mat0[i];
                        w_res.d   = w_odd ? r_tlb_d1[i]   : r_tlb_d0[i];
                        w_res.v   = w_odd ? r_tlb_v1[i]   : r_tlb_v0[i];
                    end
                end
            end
        end
    endgenerate

    assign s0_result = g_port[0].w_res;
    assign s0_index  = g_port[0].w_idx;
    assign s1_result = g_port[1].w_res;
    assign s1_index  = g_port[1].w_idx;

    always_comb begin
        w_inv_hit = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            case (inv_op)
                5'd0, 5'd1: w_inv_hit[i] = 1'b1;
                5'd2:       w_inv_hit[i] = r_tlb_g[i];
                5'd3:       w_inv_hit[i] = !r_tlb_g[i];
                5'd4:       w_inv_hit[i] = !r_tlb_g[i] && (r_tlb_asid[i] == inv_asid);
                5'd5:       w_inv_hit[i] = !r_tlb_g[i] && (r_tlb_asid[i] == inv_asid) &&
                                           va_match(r_tlb_ps[i], r_tlb_vppn[i], inv_vppn);
                5'd6:       w_inv_hit[i] = (r_tlb_g[i] || (r_tlb_asid[i] == inv_asid)) &&
                                           va_match(r_tlb_ps[i], r_tlb_vppn[i], inv_vppn);
                default:    w_inv_hit[i] = 1'b0;
            endcase
        end
    end

    // The write follows the invalidate so a same-cycle write always lands intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                r_tlb_e[i]    <= 1'b0;
                r_tlb_vppn[i] <= '0;
                r_tlb_ps[i]   <= '0;
                r_tlb_g[i]    <= 1'b0;
                r_tlb_asid[i] <= '0;
                r_tlb_ppn0[i] <= '0;
                r_tlb_plv0[i] <= '0;
                r_tlb_mat0[i] <= '0;
                r_tlb_d0[i]   <= 1'b0;
                r_tlb_v0[i]   <= 1'b0;
                r_tlb_ppn1[i] <= '0;
                r_tlb_plv1[i] <= '0;
                r_tlb_mat1[i] <= '0;
                r_tlb_d1[i]   <= 1'b0;
                r_tlb_v1[i]   <= 1'b0;
            end
        end else begin
            if (inv_en) begin
                for (int i = 0; i < TLBNUM; i++) begin
                    if (w_inv_hit[i]) begin
                        r_tlb_e[i] <= 1'b0;
                    end
                end
            end
            if (we) begin
                r_tlb_e[w_index]    <= w_e;
                r_tlb_vppn[w_index] <= w_vppn;
                r_tlb_ps[w_index]   <= w_ps;
                r_tlb_g[w_index]    <= w_g;
                r_tlb_asid[w_index] <= w_asid;
                r_tlb_ppn0[w_index] <= w_ppn0;
                r_tlb_plv0[w_index] <= w_plv0;
                r_tlb_mat0[w_index] <= w_mat0;
                r_tlb_d0[w_index]   <= w_d0;
                r_tlb_v0[w_index]   <= w_v0;
                r_tlb_ppn1[w_index] <= w_ppn1;
                r_tlb_plv1[w_index] <= w_plv1;
                r_tlb_mat1[w_index] <= w_mat1;
                r_tlb_d1[w_index]   <= w_d1;
                r_tlb_v1[w_index]   <= w_v1;
            end
        end
    end

    assign r_e    = r_tlb_e[r_index];
    assign r_vppn = r_tlb_vppn[r_index];
    assign r_ps   = r_tlb_ps[r_index];
    assign r_g    = r_tlb_g[r_index];
    assign r_asid = r_tlb_asid[r_index];
    assign r_ppn0 = r_tlb_ppn0[r_index];
    assign r_plv0 = r_tlb_plv0[r_index];
    assign r_mat0 = r_tlb_mat0[r_index];
    assign r_d0   = r_tlb_d0[r_index];
    assign r_v0   = r_tlb_v0[r_index];
    assign r_ppn1 = r_tlb_ppn1[r_index];
    assign r_plv1 = r_tlb_plv1[r_index];
    assign r_mat1 = r_tlb_mat1[r_index];
    assign r_d1   = r_tlb_d1[r_index];
    assign r_v1   = r_tlb_v1[r_index];

endmodule

`default_nettype wire

// File: tb/tb_tlb.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlb
// Brief   : Directed self-checking bench for the tlb block.
// Revision: 1.0 - initial release
// ============================================================================

module tb_tlb;
    import tlb_pkg::*;

    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    logic clk = 1'b0;
    logic reset;
    logic [18:0] s0_vppn, s1_vppn;
    logic        s0_va_bit12, s1_va_bit12;
    logic [9:0]  s0_asid, s1_asid;
    tlb_result_t s0_result, s1_result;
    logic [IDXW-1:0] s0_index, s1_index;
    logic we;
    logic [IDXW-1:0] w_index, r_index;
    logic w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [18:0] w_vppn;
    logic [5:0]  w_ps;
    logic [9:0]  w_asid;
    logic [19:0] w_ppn0, w_ppn1;
    logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1;
    logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0] r_vppn;
    logic [5:0]  r_ps;
    logic [9:0]  r_asid;
    logic [19:0] r_ppn0, r_ppn1;
    logic [1:0]  r_plv0, r_mat0, r_plv1, r_mat1;
    logic        inv_en;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tlb #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset),
        .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_result(s0_result), .s0_index(s0_index),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_result(s1_result), .s1_index(s1_index),
        .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
        .w_g(w_g), .w_asid(w_asid),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_g(r_g),
        .r_asid(r_asid),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
        .inv_en(inv_en), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tlb_result_t mk(input logic [19:0] ppn, input logic [5:0] ps,
                                       input logic [1:0] plv, input logic [1:0] mat,
                                       input logic d, input logic v);
        tlb_result_t r;
        r.found = 1'b1; r.ppn = ppn; r.ps = ps; r.plv = plv; r.mat = mat; r.d = d; r.v = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stage a write of the tag fields; page fields default to zero.
    task automatic stage_wr(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                            input logic [5:0] ps, input logic g, input logic [9:0] asid);
        we = 1'b1; w_index = idx; w_e = e; w_vppn = vppn; w_ps = ps; w_g = g; w_asid = asid;
        w_ppn0 = '0; w_plv0 = '0; w_mat0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
        w_ppn1 = '0; w_plv1 = '0; w_mat1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
    endtask

    task automatic search0(input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
        s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid;
        #1;
    endtask

    task automatic do_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
        inv_en = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
        tick();
        inv_en = 1'b0;
    endtask

    task automatic check_e(input string tag, input logic [3:0] idx, input logic exp);
        r_index = idx;
        #1;
        check(tag, 64'(r_e), 64'(exp));
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; inv_en = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
        r_index = '0;
        stage_wr(4'd0, 1'b0, '0, '0, 1'b0, '0);
        we = 1'b0;
        s0_vppn = '0; s0_va_bit12 = 1'b0; s0_asid = '0;
        s1_vppn = '0; s1_va_bit12 = 1'b0; s1_asid = '0;
        tick(); tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_s0_res", 64'(s0_result), 64'(0));
        check("rst_s0_idx", 64'(s0_index), 64'(0));
        check("rst_s1_res", 64'(s1_result), 64'(0));
        check("rst_s1_idx", 64'(s1_index), 64'(0));
        for (int i = 0; i < TLBNUM; i++) check_e("rst_r_e", 4'(i), 1'b0);

        // 4 KiB page at idx 3
        stage_wr(4'd3, 1'b1, 19'h12345, 6'd12, 1'b0, 10'd5);
        w_ppn0 = 20'hAAAAA; w_ppn1 = 20'hBBBBB; w_v1 = 1'b1; w_d1 = 1'b1;
        w_plv1 = 2'd3; w_mat1 = 2'd1;
        tick();
        we = 1'b0;
        s1_vppn = 19'h12345; s1_va_bit12 = 1'b1; s1_asid = 10'd5;
        search0(19'h12345, 1'b1, 10'd5);
        check("p4k_odd_res", 64'(s1_result), 64'(mk(20'hBBBBB, 6'd12, 2'd3, 2'd1, 1'b1, 1'b1)));
        check("p4k_odd_idx", 64'(s1_index), 64'(3));
        check("p4k_ports_eq", 64'(s0_result), 64'(mk(20'hBBBBB, 6'd12, 2'd3, 2'd1, 1'b1, 1'b1)));
        search0(19'h12345, 1'b0, 10'd5);
        check("p4k_even_res", 64'(s0_result), 64'(mk(20'hAAAAA, 6'd12, 2'd0, 2'd0, 1'b0, 1'b0)));
        search0(19'h12345, 1'b1, 10'd6);
        check("p4k_asid_miss", 64'(s0_result), 64'(0));
        check("p4k_asid_miss_idx", 64'(s0_index), 64'(0));
        r_index = 4'd3;
        #1;
        check("rd_ppn1", 64'(r_ppn1), 64'(20'hBBBBB));
        check("rd_asid", 64'(r_asid), 64'(10'd5));

        // 2 MiB global page at idx 7
        stage_wr(4'd7, 1'b1, 19'h40000, 6'd21, 1'b1, 10'd0);
        w_ppn0 = 20'h11111; w_v0 = 1'b1;
        w_ppn1 = 20'h22222; w_v1 = 1'b1; w_plv1 = 2'd2;
        tick();
        we = 1'b0;
        search0(19'h401FF, 1'b0, 10'h3FF);
        check("p2m_1ff_res", 64'(s0_result), 64'(mk(20'h22222, 6'd21, 2'd2, 2'd0, 1'b0, 1'b1)));
        check("p2m_1ff_idx", 64'(s0_index), 64'(7));
        search0(19'h40100, 1'b0, 10'h155);
        check("p2m_100_res", 64'(s0_result), 64'(mk(20'h22222, 6'd21, 2'd2, 2'd0, 1'b0, 1'b1)));
        search0(19'h40000, 1'b1, 10'h2);
        check("p2m_000_res", 64'(s0_result), 64'(mk(20'h11111, 6'd21, 2'd0, 2'd0, 1'b0, 1'b1)));
        search0(19'h40200, 1'b0, 10'h2);
        check("p2m_200_miss", 64'(s0_result), 64'(0));

        // Same-cycle write and search
        stage_wr(4'd2, 1'b1, 19'h00055, 6'd12, 1'b1, 10'd0);
        w_ppn0 = 20'h33333;
        search0(19'h00055, 1'b0, 10'd0);
        check("wr_same_cyc_miss", 64'(s0_result.found), 64'(0));
        tick();
        we = 1'b0;
        #1;
        check("wr_next_cyc_hit", 64'(s0_result), 64'(mk(20'h33333, 6'd12, 2'd0, 2'd0, 1'b0, 1'b0)));
        check("wr_next_cyc_idx", 64'(s0_index), 64'(2));

        // Duplicate entries: lowest index wins
        stage_wr(4'd5, 1'b1, 19'h00777, 6'd12, 1'b1, 10'd0);
        w_ppn0 = 20'h44444;
        tick();
        w_index = 4'd1;
        tick();
        we = 1'b0;
        search0(19'h00777, 1'b0, 10'd0);
        check("dup_lowest_idx", 64'(s0_index), 64'(1));
        check("dup_found", 64'(s0_result.found), 64'(1));

        // Invalidate ops
        reset = 1'b1; tick(); reset = 1'b0;
        stage_wr(4'd0, 1'b1, 19'h00100, 6'd12, 1'b1, 10'd0); tick();
        stage_wr(4'd1, 1'b1, 19'h00200, 6'd12, 1'b0, 10'd4); tick();
        stage_wr(4'd2, 1'b1, 19'h00300, 6'd12, 1'b0, 10'd9); tick();
        we = 1'b0;
        do_inv(5'd4, 10'd4, 19'h0);
        check_e("inv4_e0", 4'd0, 1'b1);
        check_e("inv4_e1", 4'd1, 1'b0);
        check_e("inv4_e2", 4'd2, 1'b1);
        do_inv(5'd2, 10'd0, 19'h0);
        check_e("inv2_e0", 4'd0, 1'b0);
        check_e("inv2_e2", 4'd2, 1'b1);
        do_inv(5'd9, 10'd9, 19'h00300);
        check_e("inv9_e2", 4'd2, 1'b1);
        r_index = 4'd2;
        #1;
        check("inv9_asid_kept", 64'(r_asid), 64'(10'd9));
        do_inv(5'd0, 10'd0, 19'h0);
        check_e("inv0_e2", 4'd2, 1'b0);

        // Ops 6 and 5 with VA match
        stage_wr(4'd0, 1'b1, 19'h00100, 6'd12, 1'b1, 10'd0); tick();
        stage_wr(4'd2, 1'b1, 19'h00300, 6'd12, 1'b0, 10'd9); tick();
        we = 1'b0;
        do_inv(5'd6, 10'd1, 19'h00100);
        check_e("inv6_e0", 4'd0, 1'b0);
        check_e("inv6_e2", 4'd2, 1'b1);
        do_inv(5'd5, 10'd9, 19'h00301);
        check_e("inv5_vamiss_e2", 4'd2, 1'b1);
        do_inv(5'd5, 10'd9, 19'h00300);
        check_e("inv5_e2", 4'd2, 1'b0);

        // Invalidate-all with a concurrent write
        stage_wr(4'd0, 1'b1, 19'h00100, 6'd12, 1'b1, 10'd0); tick();
        stage_wr(4'd6, 1'b1, 19'h00600, 6'd12, 1'b0, 10'd3);
        do_inv(5'd0, 10'd0, 19'h0);
        we = 1'b0;
        check_e("invwr_e6", 4'd6, 1'b1);
        check_e("invwr_e0", 4'd0, 1'b0);

        // Reset beats a concurrent write
        stage_wr(4'd4, 1'b1, 19'h00400, 6'd12, 1'b1, 10'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0; we = 1'b0;
        check_e("rstwr_e4", 4'd4, 1'b0);
        check_e("rstwr_e6", 4'd6, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
